// File: rtl/custom_ip_pkg.sv
// Shared types and constants for the reg2hw channel bank.
// Optional overflow event counter is enabled by defining CUSTOM_IP_OVF_CNT_EN.
package custom_ip_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } cmd_state_e;

   localparam int OVF_CNT_W  = 8;
   localparam int NUM_CH_DEF = 3;
   localparam int DW_DEF     = 32;

endpackage

// File: rtl/custom_ip_channel.sv
// One register-to-hardware channel: command shadow with valid/ready handoff,
// status mirror with update pulse, and overflow tracking (CUSTOM_IP_OVF_CNT_EN adds a counter).
module custom_ip_channel
   import custom_ip_pkg::*;
#(
   parameter int            DW      = DW_DEF,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 reg2ip_en_i,
   input  logic [DW-1:0]        reg2ip_data_i,
   input  logic                 ovf_clr_i,
   output logic                 ip2reg_en_o,
   output logic [DW-1:0]        ip2reg_data_o,
   output logic                 ovf_o,
`ifdef CUSTOM_IP_OVF_CNT_EN
   output logic [OVF_CNT_W-1:0] ovf_cnt_o,
`endif
   output logic                 hw_valid_o,
   input  logic                 hw_ready_i,
   output logic [DW-1:0]        hw_data_o,
   input  logic                 hw_upd_en_i,
   input  logic [DW-1:0]        hw_upd_data_i
);

   cmd_state_e    state_q, state_d;
   logic [DW-1:0] shadow_q, shadow_d;
   logic [DW-1:0] status_q, status_d;
   logic          upd_q, upd_d;
   logic          ovf_evt;

   // A write landing on a command the hardware has not yet taken drops that command.
   assign ovf_evt = (state_q == PEND) && reg2ip_en_i && !hw_ready_i;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      status_d = status_q;
      upd_d    = hw_upd_en_i;
      if (reg2ip_en_i) begin
         shadow_d = reg2ip_data_i;
         state_d  = PEND;
      end else if ((state_q == PEND) && hw_ready_i) begin
         state_d = IDLE;
      end
      if (hw_upd_en_i) begin
         status_d = hw_upd_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         shadow_q <= RST_VAL;
         status_q <= RST_VAL;
         upd_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         status_q <= status_d;
         upd_q    <= upd_d;
      end
   end

`ifdef CUSTOM_IP_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

   // Clear takes effect first so a coincident overflow still counts as one event.
   always_comb begin
      cnt_d = cnt_q;
      if (ovf_clr_i) begin
         cnt_d = ovf_evt ? OVF_CNT_W'(1) : '0;
      end else if (ovf_evt && (cnt_q != '1)) begin
         cnt_d = cnt_q + OVF_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ovf_cnt_o = cnt_q;
   assign ovf_o     = (cnt_q != '0);
`else
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_evt) begin
         ovf_d = 1'b1;
      end else if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_o = ovf_q;
`endif

   assign hw_valid_o    = (state_q == PEND);
   assign hw_data_o     = shadow_q;
   assign ip2reg_data_o = status_q;
   assign ip2reg_en_o   = upd_q;

endmodule

// File: rtl/reg2hw_channel_bank.sv
// Bank of NUM_CH independent register-to-hardware channels sliced from flat buses.
// Defining CUSTOM_IP_OVF_CNT_EN adds the per-channel ovf_cnt_o counter output.
module reg2hw_channel_bank
   import custom_ip_pkg::*;
#(
   parameter int            NUM_CH  = NUM_CH_DEF,
   parameter int            DW      = DW_DEF,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NUM_CH-1:0]           reg2ip_en_i,
   input  logic [NUM_CH*DW-1:0]        reg2ip_data_i,
   input  logic [NUM_CH-1:0]           ovf_clr_i,
   output logic [NUM_CH-1:0]           ip2reg_en_o,
   output logic [NUM_CH*DW-1:0]        ip2reg_data_o,
   output logic [NUM_CH-1:0]           ovf_o,
`ifdef CUSTOM_IP_OVF_CNT_EN
   output logic [NUM_CH*OVF_CNT_W-1:0] ovf_cnt_o,
`endif
   output logic [NUM_CH-1:0]           hw_valid_o,
   input  logic [NUM_CH-1:0]           hw_ready_i,
   output logic [NUM_CH*DW-1:0]        hw_data_o,
   input  logic [NUM_CH-1:0]           hw_upd_en_i,
   input  logic [NUM_CH*DW-1:0]        hw_upd_data_i
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      custom_ip_channel #(
         .DW      (DW),
         .RST_VAL (RST_VAL)
      ) u_channel (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .reg2ip_en_i   (reg2ip_en_i[i]),
         .reg2ip_data_i (reg2ip_data_i[i*DW +: DW]),
         .ovf_clr_i     (ovf_clr_i[i]),
         .ip2reg_en_o   (ip2reg_en_o[i]),
         .ip2reg_data_o (ip2reg_data_o[i*DW +: DW]),
         .ovf_o         (ovf_o[i]),
`ifdef CUSTOM_IP_OVF_CNT_EN
         .ovf_cnt_o     (ovf_cnt_o[i*OVF_CNT_W +: OVF_CNT_W]),
`endif
         .hw_valid_o    (hw_valid_o[i]),
         .hw_ready_i    (hw_ready_i[i]),
         .hw_data_o     (hw_data_o[i*DW +: DW]),
         .hw_upd_en_i   (hw_upd_en_i[i]),
         .hw_upd_data_i (hw_upd_data_i[i*DW +: DW])
      );
   end

endmodule

// File: tb/tb_reg2hw_channel_bank.sv
// Directed self-checking bench for reg2hw_channel_bank (default 3 x 32-bit channels);
// the counter scenario is included when CUSTOM_IP_OVF_CNT_EN is defined.
module tb_reg2hw_channel_bank;

   localparam int NUM_CH = 3;
   localparam int DW     = 32;

   logic                 clk_i;
   logic                 rst_ni;
   logic [NUM_CH-1:0]    reg2ip_en_i;
   logic [NUM_CH*DW-1:0] reg2ip_data_i;
   logic [NUM_CH-1:0]    ovf_clr_i;
   logic [NUM_CH-1:0]    ip2reg_en_o;
   logic [NUM_CH*DW-1:0] ip2reg_data_o;
   logic [NUM_CH-1:0]    ovf_o;
   logic [NUM_CH-1:0]    hw_valid_o;
   logic [NUM_CH-1:0]    hw_ready_i;
   logic [NUM_CH*DW-1:0] hw_data_o;
   logic [NUM_CH-1:0]    hw_upd_en_i;
   logic [NUM_CH*DW-1:0] hw_upd_data_i;
`ifdef CUSTOM_IP_OVF_CNT_EN
   logic [NUM_CH*8-1:0]  ovf_cnt_o;
`endif

   int tests_run;
   int tests_failed;

   reg2hw_channel_bank #(
      .NUM_CH  (NUM_CH),
      .DW      (DW),
      .RST_VAL ('0)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .reg2ip_en_i   (reg2ip_en_i),
      .reg2ip_data_i (reg2ip_data_i),
      .ovf_clr_i     (ovf_clr_i),
      .ip2reg_en_o   (ip2reg_en_o),
      .ip2reg_data_o (ip2reg_data_o),
      .ovf_o         (ovf_o),
`ifdef CUSTOM_IP_OVF_CNT_EN
      .ovf_cnt_o     (ovf_cnt_o),
`endif
      .hw_valid_o    (hw_valid_o),
      .hw_ready_i    (hw_ready_i),
      .hw_data_o     (hw_data_o),
      .hw_upd_en_i   (hw_upd_en_i),
      .hw_upd_data_i (hw_upd_data_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [DW-1:0] ch(input logic [NUM_CH*DW-1:0] bus, input int i);
      return bus[i*DW +: DW];
   endfunction

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      reg2ip_en_i   = '0;
      reg2ip_data_i = '0;
      ovf_clr_i     = '0;
      hw_ready_i    = '0;
      hw_upd_en_i   = '0;
      hw_upd_data_i = '0;
   endtask

   task automatic write_ch(input int i, input logic [DW-1:0] d);
      reg2ip_en_i             = '0;
      reg2ip_en_i[i]          = 1'b1;
      reg2ip_data_i[i*DW +: DW] = d;
   endtask

   task automatic test_reset();
      rst_ni        = 1'b0;
      reg2ip_en_i   = NUM_CH'($urandom);
      reg2ip_data_i = {$urandom, $urandom, $urandom};
      ovf_clr_i     = NUM_CH'($urandom);
      hw_ready_i    = NUM_CH'($urandom);
      hw_upd_en_i   = NUM_CH'($urandom);
      hw_upd_data_i = {$urandom, $urandom, $urandom};
      repeat (3) @(posedge clk_i);
      #1;
      tests_run++;
      if (hw_valid_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_valid: got %b want 000", hw_valid_o);
      end
      tests_run++;
      if (hw_data_o !== '0 || ip2reg_data_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_data: hw_data %h ip2reg_data %h want 0", hw_data_o, ip2reg_data_o);
      end
      tests_run++;
      if (ip2reg_en_o !== '0 || ovf_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: ip2reg_en %b ovf %b want 000", ip2reg_en_o, ovf_o);
      end
      idle_inputs();
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
   endtask

   task automatic test_single_command();
      write_ch(0, 32'hDEADBEEF);
      step();
      reg2ip_en_i = '0;
      tests_run++;
      if (hw_valid_o !== 3'b001 || ch(hw_data_o, 0) !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL cmd_rise: valid %b data %h want 001 deadbeef", hw_valid_o, ch(hw_data_o, 0));
      end
      // hw_ready_i low on two more edges while the command waits
      step();
      step();
      tests_run++;
      if (hw_valid_o !== 3'b001 || ch(hw_data_o, 0) !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("[TB] FAIL cmd_hold: valid %b data %h want 001 deadbeef", hw_valid_o, ch(hw_data_o, 0));
      end
      hw_ready_i = 3'b001;
      step();
      hw_ready_i = '0;
      tests_run++;
      if (hw_valid_o !== 3'b000 || ch(hw_data_o, 0) !== 32'hDEADBEEF || ovf_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL cmd_done: valid %b data %h ovf %b want 000 deadbeef 000",
                  hw_valid_o, ch(hw_data_o, 0), ovf_o);
      end
      // ready while idle must not create a new command
      hw_ready_i = 3'b111;
      step();
      hw_ready_i = '0;
      tests_run++;
      if (hw_valid_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL idle_ready: valid %b want 000", hw_valid_o);
      end
   endtask

   task automatic test_overflow();
      write_ch(1, 32'h1);
      step();
      reg2ip_en_i = '0;
      step();
      write_ch(1, 32'h2);
      step();
      reg2ip_en_i = '0;
      tests_run++;
      if (ovf_o !== 3'b010 || ch(hw_data_o, 1) !== 32'h2 || hw_valid_o !== 3'b010) begin
         tests_failed++;
         $display("[TB] FAIL ovf_set: ovf %b data %h valid %b want 010 2 010",
                  ovf_o, ch(hw_data_o, 1), hw_valid_o);
      end
      ovf_clr_i = 3'b010;
      step();
      ovf_clr_i = '0;
      tests_run++;
      if (ovf_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL ovf_clr: ovf %b want 000", ovf_o);
      end
      write_ch(1, 32'h3);
      ovf_clr_i = 3'b010;
      step();
      reg2ip_en_i = '0;
      ovf_clr_i   = '0;
      tests_run++;
      if (ovf_o !== 3'b010 || ch(hw_data_o, 1) !== 32'h3) begin
         tests_failed++;
         $display("[TB] FAIL ovf_set_wins: ovf %b data %h want 010 3", ovf_o, ch(hw_data_o, 1));
      end
`ifdef CUSTOM_IP_OVF_CNT_EN
      tests_run++;
      if (ovf_cnt_o[15:8] !== 8'd1) begin
         tests_failed++;
         $display("[TB] FAIL cnt_clr_set: cnt %0d want 1", ovf_cnt_o[15:8]);
      end
      for (int k = 0; k < 300; k++) begin
         write_ch(1, DW'(k));
         step();
      end
      reg2ip_en_i = '0;
      tests_run++;
      if (ovf_cnt_o[15:8] !== 8'd255 || ovf_o[1] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL cnt_sat: cnt %0d ovf %b want 255 1", ovf_cnt_o[15:8], ovf_o[1]);
      end
`endif
      ovf_clr_i  = 3'b010;
      hw_ready_i = 3'b010;
      step();
      ovf_clr_i  = '0;
      hw_ready_i = '0;
      tests_run++;
      if (ovf_o !== 3'b000 || hw_valid_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL ovf_drain: ovf %b valid %b want 000 000", ovf_o, hw_valid_o);
      end
   endtask

   task automatic test_back_to_back();
      write_ch(2, 32'hA);
      step();
      write_ch(2, 32'hB);
      hw_ready_i = 3'b100;
      step();
      reg2ip_en_i = '0;
      hw_ready_i  = '0;
      tests_run++;
      if (hw_valid_o !== 3'b100 || ch(hw_data_o, 2) !== 32'hB || ovf_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL coincident: valid %b data %h ovf %b want 100 b 000",
                  hw_valid_o, ch(hw_data_o, 2), ovf_o);
      end
      tests_run++;
      if (ch(hw_data_o, 0) !== 32'hDEADBEEF || ch(hw_data_o, 1) === 32'hB) begin
         tests_failed++;
         $display("[TB] FAIL isolation: ch0 %h ch1 %h want deadbeef and not b",
                  ch(hw_data_o, 0), ch(hw_data_o, 1));
      end
      hw_ready_i = 3'b100;
      step();
      hw_ready_i = '0;
      tests_run++;
      if (hw_valid_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL coincident_done: valid %b want 000", hw_valid_o);
      end
   endtask

   task automatic test_status();
      hw_upd_en_i        = 3'b001;
      hw_upd_data_i[31:0] = 32'h55;
      step();
      tests_run++;
      if (ip2reg_en_o !== 3'b001 || ch(ip2reg_data_o, 0) !== 32'h55) begin
         tests_failed++;
         $display("[TB] FAIL status_first: en %b data %h want 001 55", ip2reg_en_o, ch(ip2reg_data_o, 0));
      end
      hw_upd_data_i[31:0] = 32'h66;
      step();
      hw_upd_en_i = '0;
      tests_run++;
      if (ip2reg_en_o !== 3'b001 || ch(ip2reg_data_o, 0) !== 32'h66) begin
         tests_failed++;
         $display("[TB] FAIL status_second: en %b data %h want 001 66", ip2reg_en_o, ch(ip2reg_data_o, 0));
      end
      step();
      tests_run++;
      if (ip2reg_en_o !== 3'b000 || ch(ip2reg_data_o, 0) !== 32'h66 || ch(ip2reg_data_o, 1) !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL status_end: en %b ch0 %h ch1 %h want 000 66 0",
                  ip2reg_en_o, ch(ip2reg_data_o, 0), ch(ip2reg_data_o, 1));
      end
   endtask

   task automatic test_reset_mid();
      write_ch(0, 32'h1234);
      step();
      reg2ip_en_i = '0;
      tests_run++;
      if (hw_valid_o !== 3'b001) begin
         tests_failed++;
         $display("[TB] FAIL mid_pending: valid %b want 001", hw_valid_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      tests_run++;
      if (hw_valid_o !== 3'b000 || ch(hw_data_o, 0) !== 32'h0 || ip2reg_data_o !== '0) begin
         tests_failed++;
         $display("[TB] FAIL mid_async: valid %b data %h ip2reg %h want 000 0 0",
                  hw_valid_o, ch(hw_data_o, 0), ip2reg_data_o);
      end
      #2;
      rst_ni     = 1'b1;
      hw_ready_i = 3'b111;
      step();
      step();
      hw_ready_i = '0;
      tests_run++;
      if (hw_valid_o !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL mid_release: valid %b want 000", hw_valid_o);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      idle_inputs();
      test_reset();
      test_single_command();
      test_overflow();
      test_back_to_back();
      test_status();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/reg2hw_channel_bank.md
Name: reg2hw_channel_bank

Overview:
- Parametrised register-to-hardware bridge for the custom AXI IP.
- Provides NUM_CH independent channels, each DW bits wide. Each channel holds:
  - a command shadow register, written by software and delivered to the hardware core over a valid/ready handshake;
  - a status register, written by the hardware core and mirrored back to the register file with an update pulse.
- Sits between the register file (reg2ip/ip2reg side) and the IP datapath.
- Adds per-channel overflow detection, which a flat register mirror does not have.

Parameters:
- NUM_CH, 3, number of channels (1..16).
- DW, 32, data width per channel (1..64).
- RST_VAL, '0, reset value of command shadow and status registers (DW bits, same for all channels).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- reg2ip_en_i  in  NUM_CH  per-channel software write strobe, one-cycle.
- reg2ip_data_i  in  NUM_CH*DW  write data; channel i at [i*DW +: DW].
- ovf_clr_i  in  NUM_CH  per-channel software clear of sticky overflow.
- ip2reg_en_o  out  NUM_CH  per-channel status-update pulse to register file.
- ip2reg_data_o  out  NUM_CH*DW  registered status mirror.
- ovf_o  out  NUM_CH  sticky overflow flag.
- hw_valid_o  out  NUM_CH  command pending toward hardware.
- hw_ready_i  in  NUM_CH  hardware accepts command.
- hw_data_o  out  NUM_CH*DW  command data (shadow register).
- hw_upd_en_i  in  NUM_CH  hardware status write strobe.
- hw_upd_data_i  in  NUM_CH*DW  hardware status data.

Behaviour:
- Reset and clocking:
  - Reset is rst_ni, asynchronous, active-low; clock is clk_i. All state is in clk_i flops.
  - Reset values: hw_valid_o=0, hw_data_o=RST_VAL, ip2reg_data_o=RST_VAL, ip2reg_en_o=0, ovf_o=0.
- Channels are fully independent. The per-channel state below applies to each channel i.
- Command path, state machine {IDLE, PEND}; hw_valid_o = (state==PEND):
  - IDLE, reg2ip_en=1: shadow <= data, next PEND. hw_valid_o rises one cycle after the strobe.
  - PEND, hw_ready=1 and reg2ip_en=0: next IDLE. hw_data_o stays at its last value.
  - PEND, hw_ready=1 and reg2ip_en=1: the old command is accepted and the new data is loaded; stay PEND, no overflow.
  - PEND, hw_ready=0 and reg2ip_en=1: shadow overwritten with new data, stay PEND, ovf set. The lost command is not replayed.
  - PEND, hw_ready=0 and reg2ip_en=0: hold. hw_data_o must stay stable while hw_valid_o=1 and no new write arrives.
  - hw_ready is ignored in IDLE.
- Status path:
  - hw_upd_en=1: ip2reg_data_o <= hw_upd_data and ip2reg_en_o=1 on the next cycle, for exactly one cycle.
  - Back-to-back updates produce back-to-back pulses, and the last value wins.
  - Latency from hw_upd_en_i to ip2reg is exactly 1 cycle.
- Overflow, without the optional feature:
  - ovf_o is sticky and cleared by ovf_clr_i.
  - Simultaneous clear and new overflow: set wins, ovf_o stays 1.
- Reset mid-operation: a pending command is discarded, state returns to IDLE, and no handshake completes.
- Inputs outside the per-channel slice have no effect on other channels.

Optional Feature:
- Macro: CUSTOM_IP_OVF_CNT_EN.
- When defined:
  - Adds output ovf_cnt_o, NUM_CH*8 bits.
  - Per-channel 8-bit saturating counter of overflow events; it holds at 255.
  - ovf_clr_i clears the counter to 0.
  - Simultaneous clear and overflow sets the counter to 1.
  - ovf_o = (cnt != 0).
- When not defined: the port is absent and ovf_o is the plain sticky bit described above.

Decomposition:
- Package custom_ip_pkg:
  - state enum cmd_state_e {IDLE, PEND};
  - localparam OVF_CNT_W=8;
  - default NUM_CH and DW constants.
- Sub-module custom_ip_channel:
  - implements one channel (command FSM, shadow, status mirror, overflow);
  - reg2hw_channel_bank instantiates it NUM_CH times in a generate loop and slices the buses.

Test Plan:
- Reset: assert rst_ni=0 with random inputs -> all outputs at reset values; hw_valid_o=0, ip2reg_data_o=0.
- Single command: ch0 reg2ip_en with data 0xDEADBEEF, hw_ready_i=0 for 3 cycles, then 1 -> hw_valid_o[0]=1 from cycle+1 through the handshake cycle, then 0; hw_data_o stable at 0xDEADBEEF; ovf_o=0.
- Overflow: ch1 write 0x1, then write 0x2 two cycles later with hw_ready_i=0 -> ovf_o[1]=1, hw_data_o ch1=0x2. Then ovf_clr_i[1] -> ovf_o[1]=0 next cycle. With CUSTOM_IP_OVF_CNT_EN, 300 overflows -> counter reads 255.
- Write coincident with handshake: ch2 pending 0xA, hw_ready_i=1 with reg2ip_en data 0xB in the same cycle -> hw_valid_o stays 1, hw_data_o=0xB, ovf_o[2]=0.
- Status mirror: hw_upd_en_i[0] with 0x55 then 0x66 on consecutive cycles -> ip2reg_en_o[0] high for 2 cycles, ip2reg_data_o ch0=0x55 then 0x66.
- Reset mid-operation: ch0 pending command, pull rst_ni low asynchronously -> hw_valid_o[0]=0 immediately; after release, hw_valid_o stays 0 without a new write.
